carry_select_subtractor_pipe: RTL and testbench
===============================================

Name: carry_select_subtractor_pipe

Overview:
- Pipelined unsigned/two's-complement subtractor: diff = a - b - bi, with borrow-out and signed overflow.
- Built from carry-select slices with one pipeline stage per slice.
- Each slice precomputes both borrow-in variants and muxes on the incoming borrow.
- Sits in the arithmetic datapath beside the carry-select adders; ready/valid on both sides so it drops into streaming pipelines.

Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of SLICE.
- SLICE, 4, bits per carry-select slice; also the bits resolved per pipeline stage.
- (derived) STAGES = WIDTH/SLICE, 4 by default; latency in cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bi  input  1  borrow-in (1 subtracts an extra 1)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a - b - bi, modulo 2^WIDTH
- bo  output  1  borrow-out; 1 iff a < b + bi (unsigned)
- ovf  output  1  signed overflow; 1 iff sign(a) != sign(b) and sign(diff) != sign(a)

Behaviour:
- Reset (rst_n low, asynchronous): every stage valid bit is cleared, so out_valid=0.
  - diff, bo and ovf read 0 while rst_n is low.
  - in_ready = 1 from the first clock edge after release.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv.
  - Accept when in_valid && in_ready. Bubbles are not compressed; the whole pipe holds while adv = 0.
- Stage k (k = 0 .. STAGES-1) on adv:
  - Computes slice bits [k*SLICE +: SLICE] as a[slice] + ~b[slice] + c, for both c=0 and c=1.
  - Selects on the carry from stage k-1, with carry = !borrow. Stage 0 uses c = !bi.
  - Registers the slice result, the carry, and the operand bits not yet consumed.
  - Stage valid bit follows the previous stage's valid; stage 0 takes in_valid && in_ready.
- Latency: a result accepted on edge N is presented with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles of registers including the output stage, when adv is held high.
  - Throughput: 1 op per cycle.
- Output stage:
  - bo = !carry out of the top slice.
  - ovf is computed from a[WIDTH-1], b[WIDTH-1] and diff[WIDTH-1], carried down the pipe.
- Holding rules:
  - While out_valid && !out_ready, diff/bo/ovf are stable and every stage holds.
  - in_valid with in_ready=0 is ignored; the producer must hold its operands.
- No data reordering, loss or duplication. Each accepted operation yields exactly one output transfer.
- Boundary cases:
  - a == b with bi=1 gives diff all-ones, bo=1.
  - a = 0, b = 0, bi = 0 gives 0, bo=0, ovf=0.
  - A full-width borrow ripple crosses every stage and is resolved by stage muxing, not a combinational ripple.
- Reset mid-operation: in-flight operations are discarded. After release no stale out_valid appears.
- Operand X on cycles without acceptance must not propagate to the valid bits.

Test Plan:
1. a=0x1234, b=0x0234, bi=0, out_ready=1 -> exactly 4 cycles later out_valid=1, diff=0x1000, bo=0, ovf=0.
2. a=0x0000, b=0x0001, bi=0 -> diff=0xFFFF, bo=1, ovf=0. Then a=0x8000, b=0x0001 -> diff=0x7FFF, bo=0, ovf=1.
3. a=0x000F, b=0x000F, bi=1 -> diff=0xFFFF, bo=1 (borrow through all 4 slices). Then a=0x0010, b=0x000F, bi=1 -> diff=0x0000, bo=0.
4. 16 back-to-back random ops, out_ready toggled pseudo-randomly -> results match a golden model in order. in_ready equals (!out_valid || out_ready) every cycle. Outputs stable while stalled. No drop or duplicate.
5. 3 ops in flight, rst_n pulsed low mid-cycle -> out_valid falls immediately. After release, out_valid stays 0 until a new op is accepted, which then returns correctly after 4 cycles.
6. a=0x7FFF, b=0xFFFF, bi=0 -> diff=0x8000, bo=1, ovf=1. Then a=0xFFFF, b=0x7FFF, bi=0 -> diff=0x8000, bo=0, ovf=0.

Source files
------------

// File: rtl/carry_select_subtractor_pipe.sv
// carry_select_subtractor_pipe
// Pipelined subtractor computing diff = a - b - bi with borrow-out and signed
// overflow. The operands are split into SLICE-bit carry-select slices; each
// pipeline stage resolves one slice. Both carry-in variants are formed, and
// the borrow registered by the previous stage picks one of them. A borrow
// crossing the whole word therefore moves one stage per cycle. It never forms
// a combinational ripple.
// Ready/valid handshakes on both sides. The whole pipe advances as one unit,
// so bubbles are kept rather than squeezed out.
module carry_select_subtractor_pipe #(
  parameter int WIDTH = 16,
  // WIDTH must be an integer multiple of SLICE, with at least two slices.
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bo,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SLICE;
  localparam int UPPER  = WIDTH - SLICE;

  // One slice of a + ~b + c. The MSB of the result is the carry out.
  // A carry out of 1 means "no borrow".
  function automatic logic [SLICE:0] slice_sum(
    input logic [SLICE-1:0] x,
    input logic [SLICE-1:0] y,
    input logic             c
  );
    slice_sum = {1'b0, x} + {1'b0, ~y} + {{SLICE{1'b0}}, c};
  endfunction

  // Carry-select slice: form both carry-in variants, then pick one on the
  // resolved incoming carry.
  function automatic logic [SLICE:0] slice_select(
    input logic [SLICE-1:0] x,
    input logic [SLICE-1:0] y,
    input logic             carry_in
  );
    logic [SLICE:0] sum0;
    logic [SLICE:0] sum1;
    sum0 = slice_sum(x, y, 1'b0);
    sum1 = slice_sum(x, y, 1'b1);
    if (carry_in) begin
      slice_select = sum1;
    end else begin
      slice_select = sum0;
    end
  endfunction

  // Global advance enable shared by every stage.
  logic                adv_s;

  // Per-stage state. Stage STAGES-1 is the output stage.
  logic [STAGES-1:0]   valid_r;
  logic [STAGES-1:0]   borrow_r;
  logic                ovf_r;
  // Partial result. New slices enter at the top and older slices shift down.
  // After the last stage the word is complete and aligned.
  logic [WIDTH-1:0]    res_r     [STAGES];
  // Operand bits not yet consumed. The next slice to use is at the bottom.
  logic [WIDTH-1:0]    a_rem_r   [STAGES-1];
  logic [WIDTH-1:0]    b_rem_r   [STAGES-1];

  // Next-state values.
  logic [STAGES-1:0]   valid_nx_s;
  logic [STAGES-1:0]   borrow_nx_s;
  logic                ovf_nx_s;
  logic [WIDTH-1:0]    res_nx_s   [STAGES];
  logic [WIDTH-1:0]    a_rem_nx_s [STAGES-1];
  logic [WIDTH-1:0]    b_rem_nx_s [STAGES-1];
  logic [SLICE:0]      pick_s     [STAGES];

  assign adv_s     = !valid_r[STAGES-1] || out_ready;
  assign in_ready  = adv_s;
  assign out_valid = valid_r[STAGES-1];
  assign diff      = res_r[STAGES-1];
  assign bo        = borrow_r[STAGES-1];
  assign ovf       = ovf_r;

  // Per-stage slice evaluation and operand/result shifting.
  always_comb begin
    valid_nx_s  = {STAGES{1'b0}};
    borrow_nx_s = {STAGES{1'b0}};
    ovf_nx_s    = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      res_nx_s[k] = {WIDTH{1'b0}};
      pick_s[k]   = {(SLICE+1){1'b0}};
    end
    for (int k = 0; k < STAGES - 1; k++) begin
      a_rem_nx_s[k] = {WIDTH{1'b0}};
      b_rem_nx_s[k] = {WIDTH{1'b0}};
    end

    // Stage 0 works on the port operands. Its carry-in is the inverted
    // borrow-in.
    pick_s[0]      = slice_select(a[SLICE-1:0], b[SLICE-1:0], !bi);
    borrow_nx_s[0] = !pick_s[0][SLICE];
    res_nx_s[0]    = {pick_s[0][SLICE-1:0], {UPPER{1'b0}}};
    a_rem_nx_s[0]  = {{SLICE{1'b0}}, a[WIDTH-1:SLICE]};
    b_rem_nx_s[0]  = {{SLICE{1'b0}}, b[WIDTH-1:SLICE]};
    valid_nx_s[0]  = in_valid && adv_s;

    // Later stages pick their slice on the borrow registered by the
    // previous stage.
    for (int k = 1; k < STAGES; k++) begin
      pick_s[k]      = slice_select(a_rem_r[k-1][SLICE-1:0],
                                    b_rem_r[k-1][SLICE-1:0],
                                    !borrow_r[k-1]);
      borrow_nx_s[k] = !pick_s[k][SLICE];
      res_nx_s[k]    = {pick_s[k][SLICE-1:0], res_r[k-1][WIDTH-1:SLICE]};
      valid_nx_s[k]  = valid_r[k-1];
    end

    // Only stages that feed another stage keep leftover operand bits.
    for (int k = 1; k < STAGES - 1; k++) begin
      a_rem_nx_s[k] = {{SLICE{1'b0}}, a_rem_r[k-1][WIDTH-1:SLICE]};
      b_rem_nx_s[k] = {{SLICE{1'b0}}, b_rem_r[k-1][WIDTH-1:SLICE]};
    end

    // The top slice holds the operand sign bits. Signed overflow is decided
    // there, together with the sign of the result.
    ovf_nx_s = (a_rem_r[STAGES-2][SLICE-1] != b_rem_r[STAGES-2][SLICE-1]) &&
               (pick_s[STAGES-1][SLICE-1] != a_rem_r[STAGES-2][SLICE-1]);
  end

  // Pipeline registers: cleared asynchronously, all stages advance together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r  <= {STAGES{1'b0}};
      borrow_r <= {STAGES{1'b0}};
      ovf_r    <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        res_r[k] <= {WIDTH{1'b0}};
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        a_rem_r[k] <= {WIDTH{1'b0}};
        b_rem_r[k] <= {WIDTH{1'b0}};
      end
    end else if (adv_s) begin
      valid_r  <= valid_nx_s;
      borrow_r <= borrow_nx_s;
      ovf_r    <= ovf_nx_s;
      for (int k = 0; k < STAGES; k++) begin
        res_r[k] <= res_nx_s[k];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        a_rem_r[k] <= a_rem_nx_s[k];
        b_rem_r[k] <= b_rem_nx_s[k];
      end
    end
  end

endmodule

// File: tb/tb_carry_select_subtractor_pipe.sv
// Self-checking bench for carry_select_subtractor_pipe. Each accepted operation
// pushes its expected result into a scoreboard. The entry is popped and
// compared when the DUT transfers a result.
module tb_carry_select_subtractor_pipe;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = 16'h0000;
  logic [WIDTH-1:0] b = 16'h0000;
  logic             bi = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] diff;
  logic             bo;
  logic             ovf;

  carry_select_subtractor_pipe #(.WIDTH(WIDTH), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bi(bi), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bo(bo), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bo;
    logic             ovf;
    int unsigned      cyc;
  } exp_t;

  exp_t             sb_q[$];
  int               n_chk = 0;
  int               n_pass = 0;
  int unsigned      cyc = 0;
  logic             chk_lat = 1'b0;
  logic             held = 1'b0;
  logic [WIDTH+2:0] held_val;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Reference model for random operands.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
    exp_t e;
    logic [WIDTH:0] full;
    full   = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, c};
    e.diff = full[WIDTH-1:0];
    e.bo   = ({1'b0, x} < ({1'b0, y} + {{WIDTH{1'b0}}, c}));
    e.ovf  = (x[WIDTH-1] != y[WIDTH-1]) && (e.diff[WIDTH-1] != x[WIDTH-1]);
    e.cyc  = 0;
    return e;
  endfunction

  // One clock cycle. Inputs are already set just after a negedge. Returns at
  // the next negedge.
  task automatic step(input exp_t e, output logic acc);
    exp_t got;
    #1;
    check_val("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
    if (held) check_val("hold_outputs", {13'd0, out_valid, bo, ovf, diff}, {13'd0, held_val});
    held     = out_valid && !out_ready;
    held_val = {out_valid, bo, ovf, diff};
    if (out_valid && sb_q.size() == 0) begin
      check_val("spurious_out_valid", {31'd0, out_valid}, 32'd0);
    end else if (out_valid && out_ready) begin
      got = sb_q.pop_front();
      check_val("diff", {16'd0, diff}, {16'd0, got.diff});
      check_val("bo", {31'd0, bo}, {31'd0, got.bo});
      check_val("ovf", {31'd0, ovf}, {31'd0, got.ovf});
      if (chk_lat) check_val("latency", cyc - got.cyc, 32'd4);
    end
    acc = in_valid && in_ready;
    if (acc) begin
      got     = e;
      got.cyc = cyc;
      sb_q.push_back(got);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c,
                      input logic [WIDTH-1:0] d, input logic bo_e, input logic ovf_e);
    exp_t e;
    logic acc;
    int   n;
    e = '{diff: d, bo: bo_e, ovf: ovf_e, cyc: 0};
    a = x; b = y; bi = c; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      step(e, acc);
      n++;
    end
    if (!acc) check_val("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0; a = 'x; b = 'x; bi = 1'bx;
  endtask

  task automatic idle(input int n);
    exp_t e;
    logic acc;
    e = '0;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step(e, acc);
  endtask

  task automatic drain();
    exp_t e;
    logic acc;
    int   n;
    e = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 30) begin
      step(e, acc);
      n++;
    end
    if (sb_q.size() != 0) check_val("drain_timeout", sb_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic acc;
    int   sent;
    int   iter;
    logic pending;

    // Reset state
    #3;
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_diff", {16'd0, diff}, 32'd0);
    check_val("rst_bo", {31'd0, bo}, 32'd0);
    check_val("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 1: basic op with latency
    chk_lat = 1'b1;
    send(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    drain();

    // 2, 3, 6: boundaries, back to back
    send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    send(16'h000F, 16'h000F, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    send(16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b0);
    send(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    send(16'hFFFF, 16'h7FFF, 1'b0, 16'h8000, 1'b0, 1'b0);
    send(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    send(16'h5A5A, 16'h5A5A, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    drain();

    // 4: random ops with random out_ready stalls
    chk_lat = 1'b0;
    sent = 0; iter = 0; pending = 1'b0;
    while (sent < 16 && iter < 400) begin
      if (!pending) begin
        a  = WIDTH'($urandom);
        b  = WIDTH'($urandom);
        bi = 1'($urandom_range(0, 1));
        e  = model(a, b, bi);
        pending = 1'b1;
      end
      in_valid  = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      step(e, acc);
      if (acc) begin
        pending = 1'b0;
        sent++;
      end
      iter++;
    end
    if (sent != 16) check_val("random_send_timeout", sent, 32'd16);
    drain();

    // 5: reset with operations in flight
    chk_lat = 1'b1;
    send(16'h1111, 16'h0001, 1'b0, 16'h1110, 1'b0, 1'b0);
    send(16'h2222, 16'h0002, 1'b0, 16'h2220, 1'b0, 1'b0);
    send(16'h3333, 16'h0003, 1'b0, 16'h3330, 1'b0, 1'b0);
    out_ready = 1'b0;
    idle(1);
    check_val("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("midrst_diff", {16'd0, diff}, 32'd0);
    check_val("midrst_bo", {31'd0, bo}, 32'd0);
    sb_q.delete();
    held = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(6);
    check_val("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    send(16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0);
    drain();

    check_val("scoreboard_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
